foo_pipe: RTL and testbench

//  Parametrised successor to the single-shot HLS component shell.
//  - Same call/return streaming handshake (start/busy in, done/stall out).
//  - Fully pipelined: accepts one call per cycle, LATENCY stages deep.
//  - Buffers results in an internal FIFO so return-side stall never loses data.
//  - Credit counter throttles calls so in-flight + buffered results never exceed FIFO_DEPTH.
//  - Result = a*MULT + ADD, truncated to DATA_W; sits between the host call stream and return consumer.

---
 rtl/foo_pkg.sv | 20 ++
 rtl/foo_result_fifo.sv | 82 ++++++++
 rtl/foo_pipe.sv | 122 ++++++++++++
 tb/tb_foo_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/foo_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : foo_pkg
//  Brief   : Shared defaults and sizing helpers for the foo_pipe call/return
//            pipeline and its result FIFO.
//  Rev     : 1.0  initial release
// ============================================================================
package foo_pkg;

    localparam int unsigned c_def_data_w     = 64;
    localparam int unsigned c_def_latency    = 4;
    localparam int unsigned c_def_fifo_depth = 8;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage : foo_pkg
`default_nettype wire

// File: rtl/foo_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : foo_result_fifo
//  Brief   : Synchronous show-ahead FIFO holding completed results. The head
//            entry is visible on rd_data whenever the FIFO is non-empty; the
//            output reads as zero while empty. Any depth >= 1 is supported.
//  Rev     : 1.0  initial release
// ============================================================================
module foo_result_fifo
    import foo_pkg::*;
#(
    parameter int unsigned DATA_W = c_def_data_w,
    parameter int unsigned DEPTH  = c_def_fifo_depth
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_cnt_w = cnt_w(DEPTH);

    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_empty;
    logic w_rd;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : (p + c_ptr_one);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_rd    = rd_en && !w_empty;

    // Storage array; written at the tail, no reset needed because the
    // output is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (wr_en && !w_rd) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_rd && !wr_en) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty   = w_empty;
    assign count   = r_count;

endmodule : foo_result_fifo
`default_nettype wire

// File: rtl/foo_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : foo_pipe
//  Brief   : Fully pipelined call/return component computing a*MULT + ADD
//            (mod 2^DATA_W). Calls are throttled by a credit counter so that
//            in-flight plus buffered results never exceed the result FIFO.
//  Rev     : 1.0  initial release
// ============================================================================
module foo_pipe
    import foo_pkg::*;
#(
    parameter int unsigned       DATA_W     = c_def_data_w,
    parameter int unsigned       LATENCY    = c_def_latency,
    parameter int unsigned       FIFO_DEPTH = c_def_fifo_depth,
    parameter logic [DATA_W-1:0] MULT       = 1,
    parameter logic [DATA_W-1:0] ADD        = 0
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [DATA_W-1:0]             a,
    output logic                          busy,
    output logic                          done,
    input  logic                          stall,
    output logic [DATA_W-1:0]             returndata,
    output logic [cnt_w(FIFO_DEPTH)-1:0]  occupancy
);

    localparam int unsigned c_cnt_w = cnt_w(FIFO_DEPTH);

    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_credits;
    logic [c_cnt_w-1:0] w_credits_next;
    logic               r_busy;

    logic               r_vld  [LATENCY];
    logic [DATA_W-1:0]  r_data [LATENCY];

    logic               w_accept;
    logic               w_pop;
    logic               w_empty;
    logic               w_wr_en;
    logic [DATA_W-1:0]  w_wr_data;
    logic [DATA_W-1:0]  w_rd_data;
    logic [c_cnt_w-1:0] w_fifo_count;

    assign w_accept = start && !r_busy;
    assign w_pop    = !w_empty && !stall;

    // Credit update: each accept consumes one, each pop returns one.
    always_comb begin
        w_credits_next = r_credits;
        if (w_accept && !w_pop) begin
            w_credits_next = r_credits - c_cnt_one;
        end else if (w_pop && !w_accept) begin
            w_credits_next = r_credits + c_cnt_one;
        end
    end

    // Credit register and registered call-side stall; busy is held high in
    // reset and drops on the first edge after release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_credits <= c_depth;
            r_busy    <= 1'b1;
        end else begin
            r_credits <= w_credits_next;
            r_busy    <= (w_credits_next == '0);
        end
    end

    // Free-running delay line; never stalls because credits guarantee FIFO room.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i]  <= 1'b0;
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= w_accept;
            r_data[0] <= a;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    // Arithmetic sits between the last stage register and the FIFO; the
    // DATA_W-wide assignment keeps only the low product bits before ADD.
    assign w_wr_en   = r_vld[LATENCY-1];
    assign w_wr_data = (r_data[LATENCY-1] * MULT) + ADD;

    foo_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .empty   (w_empty),
        .count   (w_fifo_count)
    );

    // A write into a full FIFO without a same-cycle pop means the credit
    // accounting has broken.
    always_comb begin
        assert (!(w_wr_en && (w_fifo_count == c_depth) && !w_pop));
    end

    assign busy       = r_busy;
    assign done       = !w_empty;
    assign returndata = w_rd_data;
    assign occupancy  = c_depth - r_credits;

endmodule : foo_pipe
`default_nettype wire

// File: tb/tb_foo_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : tb_foo_pipe
//  Brief   : Directed self-checking bench for foo_pipe. Main instance uses
//            MULT=3 ADD=5; a second instance uses MULT=2 ADD=3 for wrap-around.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_foo_pipe;

    localparam int unsigned c_lat   = 4;
    localparam int unsigned c_depth = 8;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [63:0] a;
    logic        busy;
    logic        done;
    logic        stall;
    logic [63:0] returndata;
    logic [3:0]  occupancy;

    logic        start2;
    logic [63:0] a2;
    logic        busy2;
    logic        done2;
    logic        stall2;
    logic [63:0] returndata2;
    logic [3:0]  occupancy2;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] exp_q[$];

    foo_pipe #(
        .DATA_W     (64),
        .LATENCY    (c_lat),
        .FIFO_DEPTH (c_depth),
        .MULT       (64'd3),
        .ADD        (64'd5)
    ) u_dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .a          (a),
        .busy       (busy),
        .done       (done),
        .stall      (stall),
        .returndata (returndata),
        .occupancy  (occupancy)
    );

    foo_pipe #(
        .DATA_W     (64),
        .LATENCY    (c_lat),
        .FIFO_DEPTH (c_depth),
        .MULT       (64'd2),
        .ADD        (64'd3)
    ) u_dut2 (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start2),
        .a          (a2),
        .busy       (busy2),
        .done       (done2),
        .stall      (stall2),
        .returndata (returndata2),
        .occupancy  (occupancy2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: record accepted calls, compare every popped result in order.
    always @(negedge clock) begin
        if (resetn) begin
            if (done && !stall) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(done), 64'd0);
                end else begin
                    chk("result", returndata, exp_q.pop_front());
                end
            end
            if (start && !busy) begin
                exp_q.push_back(a * 64'd3 + 64'd5);
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("drain_done", 64'(done), 64'd0);
        chk("drain_data", returndata, 64'd0);
        chk("drain_occ", 64'(occupancy), 64'd0);
    endtask

    // Issue calls with a = base+idx, holding start until accepted, until
    // 'upto' calls have gone in.
    task automatic issue(input int base, inout int idx, input int upto);
        int   guard;
        logic b;
        guard = 0;
        while (idx < upto && guard < 100) begin
            start = 1'b1;
            a     = 64'(base + idx);
            b     = busy;
            tick();
            if (!b) idx++;
            guard++;
        end
        chk("issue_timeout", 64'(idx), 64'(upto));
    endtask

    initial begin
        int idx;
        int n;
        int seen;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        int seen;

        resetn = 1'b0;
        start  = 1'b0;
        a      = '0;
        stall  = 1'b0;
        start2 = 1'b0;
        a2     = '0;
        stall2 = 1'b0;

        // ---- 1: reset state, release, single call latency ----
        repeat (2) tick();
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data", returndata, 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        #2 resetn = 1'b1;
        tick();
        chk("busy_after_release", 64'(busy), 64'd0);

        start = 1'b1;
        a     = 64'd10;
        tick();
        start = 1'b0;
        chk("occ_one", 64'(occupancy), 64'd1);
        chk("done_early_0", 64'(done), 64'd0);
        for (int i = 1; i < c_lat; i++) begin
            tick();
            chk("done_early", 64'(done), 64'd0);
        end
        tick();
        chk("done_at_latency", 64'(done), 64'd1);
        chk("data_at_latency", returndata, 64'd35);
        tick();
        chk("done_after_pop", 64'(done), 64'd0);

        // ---- 2: 20 back-to-back calls ----
        for (int i = 0; i < 20; i++) begin
            start = 1'b1;
            a     = 64'(i);
            tick();
            chk("b2b_busy", 64'(busy), 64'd0);
        end
        start = 1'b0;
        drain(60);

        // ---- 3: stall held, 12 calls ----
        stall = 1'b1;
        idx   = 0;
        issue(100, idx, 8);
        chk("full_busy", 64'(busy), 64'd1);
        chk("full_occ", 64'(occupancy), 64'd8);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            a     = 64'(100 + idx);
            tick();
            chk("hold_busy", 64'(busy), 64'd1);
            chk("hold_occ", 64'(occupancy), 64'd8);
            chk("hold_data", returndata, 64'd305);
        end
        stall = 1'b0;
        issue(100, idx, 12);
        start = 1'b0;
        drain(60);

        // ---- 4: full FIFO, pop and call in the same cycle ----
        stall = 1'b1;
        idx   = 0;
        issue(200, idx, 8);
        start = 1'b0;
        repeat (c_lat) tick();
        chk("t4_occ_full", 64'(occupancy), 64'd8);
        chk("t4_done", 64'(done), 64'd1);
        stall = 1'b0;
        start = 1'b1;
        a     = 64'd300;
        tick();
        chk("t4_busy_after_pop", 64'(busy), 64'd0);
        chk("t4_occ_after_pop", 64'(occupancy), 64'd7);
        for (int i = 0; i < 6; i++) begin
            a = 64'(301 + i);
            tick();
            chk("t4_busy_steady", 64'(busy), 64'd0);
            chk("t4_occ_steady", 64'(occupancy), 64'd7);
        end
        start = 1'b0;
        drain(60);

        // ---- 5: wrap-around on second instance (MULT=2, ADD=3) ----
        start2 = 1'b1;
        a2     = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        a2     = 64'h8000_0000_0000_0000;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            tick();
            n++;
        end
        chk("wrap_done", 64'(done2), 64'd1);
        chk("wrap_data", returndata2, 64'd1);
        tick();
        chk("wrap2_done", 64'(done2), 64'd1);
        chk("wrap2_data", returndata2, 64'd3);
        tick();
        chk("wrap_empty", 64'(done2), 64'd0);

        // ---- 6: reset with 2 buffered and 3 in flight ----
        stall = 1'b1;
        idx   = 0;
        issue(400, idx, 2);
        start = 1'b0;
        repeat (c_lat) tick();
        issue(400, idx, 5);
        start = 1'b0;
        chk("t6_occ", 64'(occupancy), 64'd5);
        chk("t6_done", 64'(done), 64'd1);
        resetn = 1'b0;
        #1;
        chk("t6_rst_done", 64'(done), 64'd0);
        chk("t6_rst_occ", 64'(occupancy), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd1);
        chk("t6_rst_data", returndata, 64'd0);
        exp_q.delete();
        stall = 1'b0;
        tick();
        #2 resetn = 1'b1;
        tick();
        chk("t6_busy_release", 64'(busy), 64'd0);
        chk("t6_occ_release", 64'(occupancy), 64'd0);
        seen = 0;
        repeat (10) begin
            tick();
            if (done) seen++;
        end
        chk("t6_no_stale", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_foo_pipe
`default_nettype wire
